// File: rtl/sort_pass_ctrl.sv
// sort_pass_ctrl: sequencing controller for the 8-lane, 32-bit iterative
// odd/even sorting datapath. Owns the datapath select line, counts
// compare-exchange passes and wraps each sort in valid/ready handshakes.
// The controller never touches the 32-bit lane data itself.
//
// Optional build macro: SORT_EARLY_DONE_EN
//   Defined:   leave SORT as soon as the registered lanes are already
//              non-increasing (lane0 >= lane1 >= ... >= lane7, unsigned).
//   Undefined: sort_data is ignored; every sort runs exactly NUM_PASSES passes.
module sort_pass_ctrl #(
  parameter int unsigned NUM_PASSES = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              sel,
  input  logic [255:0]      sort_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [STAT_W-1:0] sort_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PASSES = CNT_W'(NUM_PASSES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic             accept;
  logic             handshake;
  logic             last_pass;
  logic             early_done;

  // Upstream may hand over a vector only in IDLE, and never while reset or
  // flush is pending, so an accept can never be lost to a higher-priority event.
  assign in_ready  = (state == IDLE) & ~rst & ~flush;
  assign accept    = in_valid & in_ready;
  // Flush beats the output handshake; reset is handled by priority in the flop.
  assign handshake = (state == DONE) & out_ready & ~flush;
  // One bit wider than pass_cnt so the +1 can never wrap before the compare.
  assign cnt_inc   = {1'b0, pass_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_pass = cnt_inc >= {1'b0, PASSES};

`ifdef SORT_EARLY_DONE_EN
  // Registered lanes already non-increasing: further passes cannot change them.
  always_comb begin
    early_done = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      if (sort_data[32*i +: 32] < sort_data[32*(i+1) +: 32]) early_done = 1'b0;
    end
  end
`else
  logic unused_sort_data;

  assign early_done       = 1'b0;
  assign unused_sort_data = ^sort_data;
`endif

  // Next-state and next pass count; flush overrides every state transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = pass_cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          // The accept edge itself is pass 1, since sel=1 feeds the inputs.
          if (accept) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = (NUM_PASSES <= 1) ? DONE : SORT;
          end
        end
        SORT: begin
          if (pass_cnt < PASSES) cnt_nxt = cnt_inc[CNT_W-1:0];
          if (last_pass || early_done) state_nxt = DONE;
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset outranks flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pass_cnt   <= '0;
      sort_count <= '0;
      sel        <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pass_cnt  <= cnt_nxt;
      if (handshake) sort_count <= sort_count + STAT_W'(1);
      sel       <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sort_pass_ctrl.sv
// Testbench for sort_pass_ctrl (default build, SORT_EARLY_DONE_EN only changes
// the descending-vector expectations). A behavioural odd/even datapath sits
// beside the controller; expected results are queued at accept time and a
// monitor compares them whenever out_valid is presented.
module tb_sort_pass_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, flush, sel, out_valid, out_ready, busy;
  logic [3:0]   pass_cnt;
  logic [15:0]  sort_count;
  logic [255:0] sort_data;
  logic [255:0] ext_p;
  logic [255:0] dp_q;

  // Wrap-check instance with a narrow statistics counter.
  logic         rst_w, w_in_valid, w_in_ready, w_flush, w_sel, w_out_valid, w_out_ready, w_busy;
  logic [3:0]   w_pass_cnt;
  logic [3:0]   w_sort_count;
  logic [255:0] w_sort_data;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  wrap_done = 0;

  typedef struct {
    logic [255:0] lanes;
    int           pc;
    int           sc;
    int           lat;
    int           cyc_pre;
  } exp_t;

  exp_t q[$];
  bit   seen = 0;

  sort_pass_ctrl #(.NUM_PASSES(4), .CNT_W(4), .STAT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .sel(sel), .sort_data(sort_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .pass_cnt(pass_cnt), .sort_count(sort_count)
  );

  sort_pass_ctrl #(.NUM_PASSES(4), .CNT_W(4), .STAT_W(4)) u_wrap (
    .clk(clk), .rst(rst_w), .in_valid(w_in_valid), .in_ready(w_in_ready), .flush(w_flush),
    .sel(w_sel), .sort_data(w_sort_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .busy(w_busy), .pass_cnt(w_pass_cnt), .sort_count(w_sort_count)
  );

  function automatic logic [255:0] pack8(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7[31:0], a6[31:0], a5[31:0], a4[31:0], a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
  endfunction

  // One full round: even-pair phase then odd-pair phase, larger value to lower lane.
  function automatic logic [255:0] dp_round(input logic [255:0] v);
    logic [31:0]  l[8];
    logic [31:0]  t;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) l[i] = v[32*i +: 32];
    for (int i = 0; i < 8; i += 2) if (l[i] < l[i+1]) begin t = l[i]; l[i] = l[i+1]; l[i+1] = t; end
    for (int i = 1; i < 7; i += 2) if (l[i] < l[i+1]) begin t = l[i]; l[i] = l[i+1]; l[i+1] = t; end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = l[i];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    dp_q <= dp_round(sel ? ext_p : dp_q);
  end
  assign sort_data = dp_q;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one accept edge; optionally queue its expected result.
  task automatic send(input logic [255:0] v, input logic [255:0] sorted, input int pc,
                      input int sc, input int lat, input bit push);
    exp_t e;
    ext_p    = v;
    in_valid = 1'b1;
    #1;
    chk("in_ready_at_accept", in_ready, 1);
    if (push) begin
      e.lanes = sorted; e.pc = pc; e.sc = sc; e.lat = lat; e.cyc_pre = cyc;
      q.push_back(e);
    end
    tick;
    in_valid = 1'b0;
    ext_p    = ~v;
  endtask

  task automatic wait_out_valid;
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (out_valid) ok = 1;
      else tick;
    end
    if (!ok) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (in_ready) ok = 1;
      else tick;
    end
    if (!ok) chk("timeout_idle", 0, 1);
  endtask

  // Scoreboard monitor: latency on first sight of out_valid, data on handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].cyc_pre, q[0].lat);
          seen = 1;
        end
        if (rst || flush) begin
          void'(q.pop_front());
          seen = 0;
        end else if (out_ready) begin
          chk("lanes", sort_data, q[0].lanes);
          chk("pass_cnt_done", pass_cnt, q[0].pc);
          chk("sort_count_at_hs", sort_count, q[0].sc);
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Back-to-back sorts on the narrow-counter instance: 5-cycle spacing and wrap.
  initial begin
    int last = 0;
    bit ok;
    @(negedge clk);
    while (rst_w) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        if (w_out_valid) ok = 1;
        else @(negedge clk);
      end
      if (!ok) chk("wrap_timeout", 0, 1);
      chk("wrap_count", w_sort_count, k);
      if (k > 0) chk("wrap_interval", cyc - last, 5);
      last = cyc;
      @(negedge clk);
    end
    chk("wrap_to_zero", w_sort_count, 0);
    wrap_done = 1;
  end

  localparam int DESC_LAT =
`ifdef SORT_EARLY_DONE_EN
    2;
`else
    4;
`endif

  initial begin
    logic [255:0] v_asc, v_asc_s, v_mix, v_mix_s, v_fl, v_desc;
    bit ok;
    v_asc   = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    v_asc_s = pack8(8, 7, 6, 5, 4, 3, 2, 1);
    v_mix   = pack8(5, 9, 1, 7, 3, 8, 2, 6);
    v_mix_s = pack8(9, 8, 7, 6, 5, 3, 2, 1);
    v_fl    = pack8(3, 1, 4, 1, 5, 9, 2, 6);
    v_desc  = pack8(80, 70, 60, 50, 40, 30, 20, 10);

    rst = 1; rst_w = 1; flush = 0; in_valid = 0; out_ready = 0; ext_p = '0;
    w_in_valid = 1; w_out_ready = 1; w_flush = 0; w_sort_data = v_asc;
    repeat (3) tick;
    in_valid = 1;
    #1;
    chk("in_ready_in_rst", in_ready, 0);
    in_valid = 0;
    rst = 0; rst_w = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 1);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_sort_count", sort_count, 0);

    // Ascending input, no back-pressure.
    out_ready = 1;
    send(v_asc, v_asc_s, 4, 0, 4, 1);
    chk("sel_in_sort", sel, 0);
    wait_out_valid;
    wait_idle;
    chk("sort_count_1", sort_count, 1);

    // Back-pressure holds DONE with stable lanes.
    out_ready = 0;
    send(v_mix, v_mix_s, 4, 1, 4, 1);
    wait_out_valid;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_lanes", sort_data, v_mix_s);
    end
    out_ready = 1;
    tick;
    wait_idle;
    chk("sort_count_2", sort_count, 2);

    // Flush outranks accept in IDLE.
    in_valid = 1; flush = 1;
    #1;
    chk("flush_blocks_ready", in_ready, 0);
    tick;
    chk("flush_no_accept", busy, 0);
    in_valid = 0; flush = 0;

    // Flush in the second SORT cycle.
    send(v_fl, v_fl, 0, 0, 0, 0);
    tick;
    chk("pass_cnt_sort2", pass_cnt, 2);
    flush = 1;
    tick;
    flush = 0;
    #1;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_pass_cnt", pass_cnt, 0);
    chk("flush_busy", busy, 0);
    chk("flush_sort_count", sort_count, 2);
    ok = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) ok = 0;
    end
    chk("flush_no_out_valid", ok, 1);

    // Reset in DONE with out_ready high: no handshake counted.
    out_ready = 0;
    send(v_asc, v_asc_s, 4, 2, 4, 1);
    wait_out_valid;
    rst = 1; out_ready = 1;
    #1;
    chk("rst_done_in_ready", in_ready, 0);
    tick;
    rst = 0;
    #1;
    chk("rst_done_sort_count", sort_count, 0);
    chk("rst_done_out_valid", out_valid, 0);
    chk("rst_done_sel", sel, 1);
    chk("rst_done_pass_cnt", pass_cnt, 0);
    chk("rst_done_queue", q.size(), 0);

    // Already-descending input.
    send(v_desc, v_desc, DESC_LAT, 0, DESC_LAT, 1);
    wait_out_valid;
    chk("desc_pass_cnt", pass_cnt, DESC_LAT);
    wait_idle;
    chk("desc_sort_count", sort_count, 1);

    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (wrap_done) ok = 1;
      else tick;
    end
    if (!ok) chk("wrap_not_finished", 0, 1);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
